ivshift_exec_stage: RTL and testbench

//  Pipelined packed-SIMD shift execution stage that wraps the combinational packed shifter.
//  - Accepts shift micro-ops from the integer issue queue through a valid/ready handshake.
//  - Registers the operands (S0), then drives them into the shifter.
//  - Registers the shifter result together with its ROB tag (S1) and presents it to writeback

---
 rtl/ivshift_exec_stage.sv | 180 ++++++++++++++++++
 tb/tb_ivshift_exec_stage.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivshift_exec_stage.sv
// Two-stage packed-SIMD shift execution stage: S0 registers the issued operands, S1 registers
// the shifter result and ROB tag for writeback. Both boundaries use valid/ready flow control.
module ivshift_exec_stage #(
    parameter int unsigned ROB_W = 6
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_resetn_i,
    input  logic             flush_i,
    input  logic             uop_valid_i,
    output logic             uop_ready_o,
    input  logic [ROB_W-1:0] uop_tag_i,
    input  logic [31:0]      uop_rs1_i,
    input  logic [31:0]      uop_rs2_i,
    input  logic [4:0]       uop_imm_i,
    input  logic             uop_use_imm_i,
    input  logic             uop_size_i,
    input  logic [2:0]       uop_op_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [ROB_W-1:0] wb_tag_o,
    output logic [31:0]      wb_data_o,
    output logic             wb_illegal_o
);

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_ROL = 3'b010,
        OP_ROR = 3'b011,
        OP_SRA = 3'b101
    } shift_op_e;

    logic             s0_valid_q, s0_valid_d;
    logic [ROB_W-1:0] s0_tag_q, s0_tag_d;
    logic [31:0]      s0_rs1_q, s0_rs1_d;
    logic [31:0]      s0_b_q, s0_b_d;
    logic             s0_size_q, s0_size_d;
    logic [2:0]       s0_op_q, s0_op_d;

    logic             s1_valid_q, s1_valid_d;
    logic [ROB_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      s1_data_q, s1_data_d;
    logic             s1_illegal_q, s1_illegal_d;

    logic             s0_adv;
    logic             accept;
    logic             op_legal;
    logic [31:0]      byte_res;
    logic [31:0]      half_res;
    logic [31:0]      shift_res;
    logic             unused_amt_bits;

    function automatic logic [7:0] lane8(input logic [7:0] a, input logic [2:0] s,
                                         input logic [2:0] op);
        logic [15:0] dbl;
        logic [7:0]  r;
        dbl = {a, a};
        r   = '0;
        case (op)
            OP_SLL: r = a << s;
            OP_SRL: r = a >> s;
            OP_ROL: begin dbl = dbl << s; r = dbl[15:8]; end
            OP_ROR: begin dbl = dbl >> s; r = dbl[7:0];  end
            OP_SRA: r = $signed(a) >>> s;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] lane16(input logic [15:0] a, input logic [3:0] s,
                                           input logic [2:0] op);
        logic [31:0] dbl;
        logic [15:0] r;
        dbl = {a, a};
        r   = '0;
        case (op)
            OP_SLL: r = a << s;
            OP_SRL: r = a >> s;
            OP_ROL: begin dbl = dbl << s; r = dbl[31:16]; end
            OP_ROR: begin dbl = dbl >> s; r = dbl[15:0];  end
            OP_SRA: r = $signed(a) >>> s;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Shift-amount bits beyond the lane width never reach the shifter.
    assign unused_amt_bits = ^{s0_b_q[31:27], s0_b_q[23:20], s0_b_q[15:11], s0_b_q[7:4]};

    always_comb begin
        s0_adv      = s0_valid_q && (!s1_valid_q || wb_ready_i);
        uop_ready_o = !flush_i && (!s0_valid_q || s0_adv);
        accept      = uop_valid_i && uop_ready_o;
    end

    always_comb begin
        byte_res = '0;
        half_res = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_res[8*i +: 8] = lane8(s0_rs1_q[8*i +: 8], s0_b_q[8*i +: 3], s0_op_q);
        end
        for (int unsigned j = 0; j < 2; j++) begin
            half_res[16*j +: 16] = lane16(s0_rs1_q[16*j +: 16], s0_b_q[16*j +: 4], s0_op_q);
        end
        op_legal  = s0_op_q inside {OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SRA};
        shift_res = !op_legal ? '0 : (s0_size_q ? half_res : byte_res);
    end

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_tag_d   = s0_tag_q;
        s0_rs1_d   = s0_rs1_q;
        s0_b_d     = s0_b_q;
        s0_size_d  = s0_size_q;
        s0_op_d    = s0_op_q;
        if (flush_i) begin
            s0_valid_d = 1'b0;
        end else if (accept) begin
            s0_valid_d = 1'b1;
            s0_tag_d   = uop_tag_i;
            s0_rs1_d   = uop_rs1_i;
            s0_b_d     = uop_use_imm_i ? {4{3'b000, uop_imm_i}} : uop_rs2_i;
            s0_size_d  = uop_size_i;
            s0_op_d    = uop_op_i;
        end else if (s0_adv) begin
            s0_valid_d = 1'b0;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_tag_d     = s1_tag_q;
        s1_data_d    = s1_data_q;
        s1_illegal_d = s1_illegal_q;
        if (flush_i) begin
            s1_valid_d = 1'b0;
        end else if (s0_adv) begin
            s1_valid_d   = 1'b1;
            s1_tag_d     = s0_tag_q;
            s1_data_d    = shift_res;
            s1_illegal_d = !op_legal;
        end else if (wb_ready_i) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            s0_valid_q   <= 1'b0;
            s0_tag_q     <= '0;
            s0_rs1_q     <= '0;
            s0_b_q       <= '0;
            s0_size_q    <= 1'b0;
            s0_op_q      <= '0;
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= '0;
            s1_data_q    <= '0;
            s1_illegal_q <= 1'b0;
        end else begin
            s0_valid_q   <= s0_valid_d;
            s0_tag_q     <= s0_tag_d;
            s0_rs1_q     <= s0_rs1_d;
            s0_b_q       <= s0_b_d;
            s0_size_q    <= s0_size_d;
            s0_op_q      <= s0_op_d;
            s1_valid_q   <= s1_valid_d;
            s1_tag_q     <= s1_tag_d;
            s1_data_q    <= s1_data_d;
            s1_illegal_q <= s1_illegal_d;
        end
    end

    always_comb begin
        wb_valid_o   = s1_valid_q;
        wb_tag_o     = s1_tag_q;
        wb_data_o    = s1_data_q;
        wb_illegal_o = s1_illegal_q;
    end

endmodule

// File: tb/tb_ivshift_exec_stage.sv
// Directed bench for ivshift_exec_stage: vector table for lane arithmetic plus hand-written
// sequences for streaming, backpressure, flush and asynchronous reset.
module tb_ivshift_exec_stage;

    localparam int unsigned ROB_W = 6;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             uop_valid;
    logic             uop_ready;
    logic [ROB_W-1:0] uop_tag;
    logic [31:0]      uop_rs1;
    logic [31:0]      uop_rs2;
    logic [4:0]       uop_imm;
    logic             uop_use_imm;
    logic             uop_size;
    logic [2:0]       uop_op;
    logic             wb_valid;
    logic             wb_ready;
    logic [ROB_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             wb_illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]       op;
        logic             size;
        logic             use_imm;
        logic [4:0]       imm;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [ROB_W-1:0] tag;
        logic [31:0]      exp_data;
        logic             exp_ill;
    } vec_t;

    vec_t vecs[13];

    ivshift_exec_stage #(.ROB_W(ROB_W)) dut (
        .cpu_clock_i   (clk),
        .cpu_resetn_i  (rst_n),
        .flush_i       (flush),
        .uop_valid_i   (uop_valid),
        .uop_ready_o   (uop_ready),
        .uop_tag_i     (uop_tag),
        .uop_rs1_i     (uop_rs1),
        .uop_rs2_i     (uop_rs2),
        .uop_imm_i     (uop_imm),
        .uop_use_imm_i (uop_use_imm),
        .uop_size_i    (uop_size),
        .uop_op_i      (uop_op),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_tag_o      (wb_tag),
        .wb_data_o     (wb_data),
        .wb_illegal_o  (wb_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uop(input logic v, input logic [ROB_W-1:0] tag, input logic [2:0] op,
                           input logic sz, input logic ui, input logic [4:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2);
        uop_valid   = v;
        uop_tag     = tag;
        uop_op      = op;
        uop_size    = sz;
        uop_use_imm = ui;
        uop_imm     = imm;
        uop_rs1     = rs1;
        uop_rs2     = rs2;
    endtask

    task automatic check_reset_outputs(input string tag_name);
        check({tag_name, "_wb_valid"},   32'(wb_valid),   32'd0);
        check({tag_name, "_wb_tag"},     32'(wb_tag),     32'd0);
        check({tag_name, "_wb_data"},    wb_data,         32'd0);
        check({tag_name, "_wb_illegal"}, 32'(wb_illegal), 32'd0);
        check({tag_name, "_uop_ready"},  32'(uop_ready),  32'd1);
    endtask

    // Issue one uop into an empty pipeline and expect its result exactly two cycles later.
    task automatic issue_and_check(input vec_t v, input string name);
        wb_ready = 1'b1;
        set_uop(1'b1, v.tag, v.op, v.size, v.use_imm, v.imm, v.rs1, v.rs2);
        #1;
        check({name, "_ready"}, 32'(uop_ready), 32'd1);
        tick();
        set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check({name, "_valid_n1"}, 32'(wb_valid), 32'd0);
        tick();
        #1;
        check({name, "_valid_n2"}, 32'(wb_valid),   32'd1);
        check({name, "_tag"},      32'(wb_tag),     32'(v.tag));
        check({name, "_data"},     wb_data,         v.exp_data);
        check({name, "_illegal"},  32'(wb_illegal), 32'(v.exp_ill));
        tick();
    endtask

    function automatic logic [31:0] ref_ror(input logic [31:0] a, input logic [31:0] b,
                                            input logic size);
        logic [31:0] r;
        int unsigned len;
        int unsigned amt;
        int unsigned base;
        r   = '0;
        len = size ? 16 : 8;
        for (int unsigned l = 0; l < 32 / len; l++) begin
            base = l * len;
            amt  = size ? 32'(b[base +: 4]) : 32'(b[base +: 3]);
            for (int unsigned j = 0; j < len; j++) begin
                r[base + j] = a[base + ((j + amt) % len)];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ror_rs1(input int i);
        return 32'hA5C3_0F81 ^ (32'(i) * 32'h1357_9BDF);
    endfunction

    function automatic logic [31:0] ror_rs2(input int i);
        return (32'(i) * 32'h0301_0502) + 32'h0005_0003;
    endfunction

    initial begin
        int k;
        int acc;
        int nres;
        int seen;
        vec_t post;

        //            op      sz    imm   immv    rs1            rs2            tag    data           ill
        vecs[0]  = '{3'b000, 1'b0, 1'b0, 5'd0,  32'h0102_0304, 32'h0101_0101, 6'd1,  32'h0204_0608, 1'b0};
        vecs[1]  = '{3'b101, 1'b1, 1'b1, 5'd4,  32'h8000_4000, 32'h0000_0000, 6'd2,  32'hF800_0400, 1'b0};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 5'd0,  32'h80FF_1008, 32'h0701_0302, 6'd3,  32'h017F_0202, 1'b0};
        vecs[3]  = '{3'b010, 1'b0, 1'b1, 5'd4,  32'h810F_F012, 32'hFFFF_FFFF, 6'd4,  32'h18F0_0F21, 1'b0};
        vecs[4]  = '{3'b011, 1'b1, 1'b0, 5'd0,  32'h1234_8001, 32'h0004_0001, 6'd5,  32'h4123_C000, 1'b0};
        vecs[5]  = '{3'b101, 1'b0, 1'b0, 5'd0,  32'h807F_FE01, 32'h0107_0100, 6'd6,  32'hC000_FF01, 1'b0};
        vecs[6]  = '{3'b110, 1'b0, 1'b0, 5'd0,  32'hFFFF_FFFF, 32'h0101_0101, 6'd7,  32'h0000_0000, 1'b1};
        vecs[7]  = '{3'b100, 1'b1, 1'b0, 5'd0,  32'h1234_5678, 32'h0001_0001, 6'd8,  32'h0000_0000, 1'b1};
        vecs[8]  = '{3'b111, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF, 32'h0000_0000, 6'd9,  32'h0000_0000, 1'b1};
        vecs[9]  = '{3'b000, 1'b0, 1'b1, 5'd29, 32'h0101_0101, 32'h0000_0000, 6'd10, 32'h2020_2020, 1'b0};
        vecs[10] = '{3'b000, 1'b1, 1'b1, 5'd19, 32'h0001_1001, 32'h0000_0000, 6'd11, 32'h0008_8008, 1'b0};
        vecs[11] = '{3'b001, 1'b1, 1'b0, 5'd0,  32'hFFFF_8000, 32'hFFF8_FFF2, 6'd12, 32'h00FF_2000, 1'b0};
        vecs[12] = '{3'b010, 1'b1, 1'b1, 5'd15, 32'h8000_0001, 32'h0000_0000, 6'd13, 32'h4000_8000, 1'b0};

        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            issue_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // Ten back-to-back ror uops at full throughput.
        wb_ready = 1'b1;
        nres = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 10)
                set_uop(1'b1, 6'(40 + cyc), 3'b011, cyc[0], 1'b0, 5'd0, ror_rs1(cyc), ror_rs2(cyc));
            else
                set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            #1;
            if (cyc < 10) check("stream_ready", 32'(uop_ready), 32'd1);
            if (wb_valid) begin
                check("stream_tag",   32'(wb_tag), 32'(40 + nres));
                check("stream_data",  wb_data, ref_ror(ror_rs1(nres), ror_rs2(nres), nres[0]));
                check("stream_cycle", 32'(cyc), 32'(nres + 2));
                nres++;
            end
            tick();
        end
        check("stream_count", 32'(nres), 32'd10);

        // Backpressure: three uops offered while writeback stalls for four cycles.
        wb_ready = 1'b0;
        k = 0;
        acc = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            set_uop(1'b1, 6'(20 + k), 3'b000, 1'b0, 1'b0, 5'd0, 32'h1111_1111 * 32'(k + 1), 32'd0);
            #1;
            if (uop_ready) begin
                acc++;
                k++;
            end
            if (cyc >= 2) begin
                check("bp_ready_low",   32'(uop_ready),  32'd0);
                check("bp_hold_valid",  32'(wb_valid),   32'd1);
                check("bp_hold_tag",    32'(wb_tag),     32'd20);
                check("bp_hold_data",   wb_data,         32'h1111_1111);
                check("bp_hold_ill",    32'(wb_illegal), 32'd0);
            end
            tick();
        end
        check("bp_accepted", 32'(acc), 32'd2);
        wb_ready = 1'b1;
        nres = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (k < 3)
                set_uop(1'b1, 6'(20 + k), 3'b000, 1'b0, 1'b0, 5'd0, 32'h1111_1111 * 32'(k + 1), 32'd0);
            else
                set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            #1;
            if (wb_valid) begin
                check("bp_rel_tag",  32'(wb_tag), 32'(20 + nres));
                check("bp_rel_data", wb_data, 32'h1111_1111 * 32'(nres + 1));
                nres++;
            end
            if (uop_valid && uop_ready) k++;
            tick();
        end
        check("bp_rel_count", 32'(nres), 32'd3);

        // Flush with both stages full; a uop offered in the flush cycle must be refused.
        wb_ready = 1'b0;
        set_uop(1'b1, 6'd30, 3'b000, 1'b0, 1'b0, 5'd0, 32'hAAAA_0030, 32'd0);
        #1;
        check("fl_acc30", 32'(uop_ready), 32'd1);
        tick();
        set_uop(1'b1, 6'd31, 3'b000, 1'b0, 1'b0, 5'd0, 32'hAAAA_0031, 32'd0);
        #1;
        check("fl_acc31", 32'(uop_ready), 32'd1);
        tick();
        flush = 1'b1;
        set_uop(1'b1, 6'd32, 3'b000, 1'b0, 1'b0, 5'd0, 32'hAAAA_0032, 32'd0);
        #1;
        check("fl_full_valid", 32'(wb_valid),  32'd1);
        check("fl_full_tag",   32'(wb_tag),    32'd30);
        check("fl_ready_low",  32'(uop_ready), 32'd0);
        tick();
        flush = 1'b0;
        set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        wb_ready = 1'b1;
        #1;
        check("fl_valid_after", 32'(wb_valid),  32'd0);
        check("fl_ready_after", 32'(uop_ready), 32'd1);
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (wb_valid) seen++;
            tick();
        end
        check("fl_killed_seen", 32'(seen), 32'd0);
        post = '{3'b001, 1'b1, 1'b1, 5'd1, 32'h0002_0004, 32'd0, 6'd33, 32'h0001_0002, 1'b0};
        issue_and_check(post, "fl_post");

        // Illegal op stalled at writeback, then asynchronous reset between clock edges.
        wb_ready = 1'b0;
        set_uop(1'b1, 6'd7, 3'b110, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0303_0303);
        #1;
        check("ill_acc", 32'(uop_ready), 32'd1);
        tick();
        set_uop(1'b1, 6'd8, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0000_0001, 32'd0);
        #1;
        check("ill_acc2", 32'(uop_ready), 32'd1);
        tick();
        set_uop(1'b0, '0, 3'b000, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        check("ill_valid",   32'(wb_valid),   32'd1);
        check("ill_tag",     32'(wb_tag),     32'd7);
        check("ill_data",    wb_data,         32'd0);
        check("ill_illegal", 32'(wb_illegal), 32'd1);
        check("ill_ready",   32'(uop_ready),  32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wb_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            if (wb_valid) seen++;
        end
        check("rst_no_leftover", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
